// File: rtl/test_sig_gen.sv
// test_sig_gen: two-channel square-wave generator with programmable period,
// high time and phase offset of out_b behind out_a. All outputs are registered.
// Optional build macro TSG_PCNT_EN adds a 32-bit completed-period counter
// output (pcnt); without it the port and its counter are absent.
module test_sig_gen #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [CNT_W-1:0] cfg_period,
   input  logic [CNT_W-1:0] cfg_high,
   input  logic [CNT_W-1:0] cfg_phase,
   output logic             cfg_err,
   input  logic             enable,
   output logic             busy,
   output logic             out_a,
   output logic             out_b
`ifdef TSG_PCNT_EN
   ,
   output logic [31:0]      pcnt
`endif
);

   localparam int unsigned PCNT_W = 32;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_STOP = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;

   // Shadow (staged) configuration and its pending flag
   logic [CNT_W-1:0]   r_sh_period, r_sh_high, r_sh_phase;
   logic [CNT_W-1:0]   w_sh_period_nxt, w_sh_high_nxt, w_sh_phase_nxt;
   logic               r_pend, w_pend_nxt;

   // Active configuration driving the counters
   logic [CNT_W-1:0]   r_act_period, r_act_high, r_act_phase;
   logic [CNT_W-1:0]   w_act_period_nxt, w_act_high_nxt, w_act_phase_nxt;
   logic               r_loaded, w_loaded_nxt;

   // Waveform counters
   logic [CNT_W-1:0]   r_cnt_a, r_cnt_b;
   logic [CNT_W-1:0]   w_cnt_a_nxt, w_cnt_b_nxt;
   logic [CNT_W-1:0]   w_cnt_a_inc, w_cnt_b_inc;
   logic               w_wrap_a, w_wrap_b;

   // Registered outputs
   logic               r_out_a, r_out_b, r_busy, r_cfg_err;
   logic               w_out_a_nxt, w_out_b_nxt, w_busy_nxt, w_cfg_err_nxt;

   // Control strobes
   logic               w_xfer, w_cfg_ok, w_apply, w_start, w_reload;

   assign cfg_ready = ~r_pend;
   assign cfg_err   = r_cfg_err;
   assign busy      = r_busy;
   assign out_a     = r_out_a;
   assign out_b     = r_out_b;

   // Handshake qualification and configuration validity
   assign w_xfer   = cfg_valid && !r_pend;
   assign w_cfg_ok = (cfg_period >= CNT_W'(2)) &&
                     (cfg_high != '0) &&
                     (cfg_high < cfg_period) &&
                     (cfg_phase < cfg_period);

   // Free-running increments with wrap at period-1
   assign w_wrap_a    = (r_cnt_a == (r_act_period - CNT_W'(1)));
   assign w_wrap_b    = (r_cnt_b == (r_act_period - CNT_W'(1)));
   assign w_cnt_a_inc = w_wrap_a ? '0 : (r_cnt_a + CNT_W'(1));
   assign w_cnt_b_inc = w_wrap_b ? '0 : (r_cnt_b + CNT_W'(1));

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, configuration transfer, counter and output decode
   always_comb begin
      w_state_nxt      = r_state;
      w_sh_period_nxt  = r_sh_period;
      w_sh_high_nxt    = r_sh_high;
      w_sh_phase_nxt   = r_sh_phase;
      w_pend_nxt       = r_pend;
      w_act_period_nxt = r_act_period;
      w_act_high_nxt   = r_act_high;
      w_act_phase_nxt  = r_act_phase;
      w_loaded_nxt     = r_loaded;
      w_cnt_a_nxt      = r_cnt_a;
      w_cnt_b_nxt      = r_cnt_b;
      w_cfg_err_nxt    = 1'b0;
      w_apply          = 1'b0;
      w_start          = 1'b0;
      w_reload         = 1'b0;
      w_out_a_nxt      = 1'b0;
      w_out_b_nxt      = 1'b0;
      w_busy_nxt       = 1'b0;

      // Accept into the shadow register, or discard and flag
      if (w_xfer) begin
         if (w_cfg_ok) begin
            w_sh_period_nxt = cfg_period;
            w_sh_high_nxt   = cfg_high;
            w_sh_phase_nxt  = cfg_phase;
            w_pend_nxt      = 1'b1;
         end else begin
            w_cfg_err_nxt = 1'b1;
         end
      end

      case (r_state)
         S_IDLE: begin
            if (r_pend) begin
               w_apply = 1'b1;
            end
            if (enable && r_loaded) begin
               w_state_nxt = S_RUN;
               w_start     = 1'b1;
            end
         end
         S_RUN: begin
            if (!enable) begin
               w_state_nxt = w_wrap_a ? S_IDLE : S_STOP;
            end else if (w_wrap_a && r_pend) begin
               w_apply = 1'b1;
            end
         end
         S_STOP: begin
            if (enable) begin
               w_state_nxt = S_RUN;
               if (w_wrap_a && r_pend) begin
                  w_apply = 1'b1;
               end
            end else if (w_wrap_a) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      // Copy shadow to active; pending clears, active becomes loaded
      if (w_apply) begin
         w_act_period_nxt = r_sh_period;
         w_act_high_nxt   = r_sh_high;
         w_act_phase_nxt  = r_sh_phase;
         w_pend_nxt       = 1'b0;
         w_loaded_nxt     = 1'b1;
      end

      // Counters restart on start or on a boundary reload
      w_reload = w_start || (w_apply && (r_state != S_IDLE));

      if (w_state_nxt == S_IDLE) begin
         w_cnt_a_nxt = '0;
         w_cnt_b_nxt = '0;
      end else if (w_reload) begin
         w_cnt_a_nxt = '0;
         w_cnt_b_nxt = (w_act_phase_nxt == '0) ? '0
                                               : (w_act_period_nxt - w_act_phase_nxt);
      end else begin
         w_cnt_a_nxt = w_cnt_a_inc;
         w_cnt_b_nxt = w_cnt_b_inc;
      end

      // Outputs follow the next counter values; forced low in IDLE
      w_busy_nxt  = (w_state_nxt != S_IDLE);
      w_out_a_nxt = w_busy_nxt && (w_cnt_a_nxt < w_act_high_nxt);
      w_out_b_nxt = w_busy_nxt && (w_cnt_b_nxt < w_act_high_nxt);
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sh_period  <= '0;
         r_sh_high    <= '0;
         r_sh_phase   <= '0;
         r_pend       <= 1'b0;
         r_act_period <= '0;
         r_act_high   <= '0;
         r_act_phase  <= '0;
         r_loaded     <= 1'b0;
         r_cnt_a      <= '0;
         r_cnt_b      <= '0;
         r_out_a      <= 1'b0;
         r_out_b      <= 1'b0;
         r_busy       <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_sh_period  <= w_sh_period_nxt;
         r_sh_high    <= w_sh_high_nxt;
         r_sh_phase   <= w_sh_phase_nxt;
         r_pend       <= w_pend_nxt;
         r_act_period <= w_act_period_nxt;
         r_act_high   <= w_act_high_nxt;
         r_act_phase  <= w_act_phase_nxt;
         r_loaded     <= w_loaded_nxt;
         r_cnt_a      <= w_cnt_a_nxt;
         r_cnt_b      <= w_cnt_b_nxt;
         r_out_a      <= w_out_a_nxt;
         r_out_b      <= w_out_b_nxt;
         r_busy       <= w_busy_nxt;
         r_cfg_err    <= w_cfg_err_nxt;
      end
   end

`ifdef TSG_PCNT_EN
   logic [PCNT_W-1:0] r_pcnt;

   assign pcnt = r_pcnt;

   // Completed out_a periods since start; saturates, holds in IDLE
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pcnt <= '0;
      end else if (w_start) begin
         r_pcnt <= '0;
      end else if ((r_state != S_IDLE) && w_wrap_a && (r_pcnt != '1)) begin
         r_pcnt <= r_pcnt + PCNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_test_sig_gen.sv
// Directed self-checking bench for test_sig_gen.
module tb_test_sig_gen;

   logic        clk;
   logic        rst_n;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [31:0] cfg_period;
   logic [31:0] cfg_high;
   logic [31:0] cfg_phase;
   logic        cfg_err;
   logic        enable;
   logic        busy;
   logic        out_a;
   logic        out_b;
`ifdef TSG_PCNT_EN
   logic [31:0] pcnt;
`endif

   int n_pass;
   int n_total;

   test_sig_gen #(.CNT_W(32)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .cfg_valid  (cfg_valid),
      .cfg_ready  (cfg_ready),
      .cfg_period (cfg_period),
      .cfg_high   (cfg_high),
      .cfg_phase  (cfg_phase),
      .cfg_err    (cfg_err),
      .enable     (enable),
      .busy       (busy),
      .out_a      (out_a),
      .out_b      (out_b)
`ifdef TSG_PCNT_EN
      ,
      .pcnt       (pcnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic send_cfg(input logic [31:0] p, input logic [31:0] h, input logic [31:0] ph);
      cfg_valid  = 1'b1;
      cfg_period = p;
      cfg_high   = h;
      cfg_phase  = ph;
      tick();
      cfg_valid  = 1'b0;
   endtask

   initial begin
      n_pass     = 0;
      n_total    = 0;
      rst_n      = 1'b0;
      cfg_valid  = 1'b0;
      cfg_period = '0;
      cfg_high   = '0;
      cfg_phase  = '0;
      enable     = 1'b0;

      // Reset state
      tick();
      tick();
      check("rst_out_a", 32'(out_a), 0);
      check("rst_out_b", 32'(out_b), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_cfg_ready", 32'(cfg_ready), 1);
      check("rst_cfg_err", 32'(cfg_err), 0);
      rst_n = 1'b1;
      tick();

      // period=10 high=4 phase=0
      send_cfg(32'd10, 32'd4, 32'd0);
      check("p10_pend_ready", 32'(cfg_ready), 0);
      tick();
      check("p10_copied_ready", 32'(cfg_ready), 1);
      check("p10_idle_out_a", 32'(out_a), 0);
      enable = 1'b1;
      tick();
`ifdef TSG_PCNT_EN
      check("p10_pcnt_start", pcnt, 0);
`endif
      check("p10_busy", 32'(busy), 1);
      for (int k = 0; k < 20; k++) begin
         check($sformatf("p10_a_k%0d", k), 32'(out_a), 32'((k % 10) < 4));
         check($sformatf("p10_b_k%0d", k), 32'(out_b), 32'((k % 10) < 4));
         tick();
      end
      tick();
      tick();
      // Drop enable at cnt_a=2
      enable = 1'b0;
      tick();
      check("stop_busy_c3", 32'(busy), 1);
      check("stop_out_a_c3", 32'(out_a), 1);
      repeat (6) tick();
      check("stop_busy_c9", 32'(busy), 1);
      check("stop_out_a_c9", 32'(out_a), 0);
      tick();
      check("stop_end_busy", 32'(busy), 0);
      check("stop_end_out_a", 32'(out_a), 0);
      check("stop_end_out_b", 32'(out_b), 0);
`ifdef TSG_PCNT_EN
      check("stop_pcnt", pcnt, 3);
`endif
      tick();
      check("idle_hold_busy", 32'(busy), 0);

      // Invalid configurations
      send_cfg(32'd1, 32'd1, 32'd0);
      check("bad_period_err", 32'(cfg_err), 1);
      check("bad_period_ready", 32'(cfg_ready), 1);
      tick();
      check("bad_period_err_clr", 32'(cfg_err), 0);
      send_cfg(32'd10, 32'd0, 32'd0);
      check("bad_high_err", 32'(cfg_err), 1);
      tick();
      check("bad_high_err_clr", 32'(cfg_err), 0);
      send_cfg(32'd10, 32'd4, 32'd10);
      check("bad_phase_err", 32'(cfg_err), 1);
      check("bad_phase_ready", 32'(cfg_ready), 1);
      tick();
      check("bad_phase_err_clr", 32'(cfg_err), 0);
      check("bad_out_a", 32'(out_a), 0);
      check("bad_busy", 32'(busy), 0);

      // period=10 high=5 phase=3 over 20 periods
      send_cfg(32'd10, 32'd5, 32'd3);
      check("ph3_err", 32'(cfg_err), 0);
      tick();
      enable = 1'b1;
      tick();
      for (int k = 0; k < 200; k++) begin
         check($sformatf("ph3_a_k%0d", k), 32'(out_a), 32'((k % 10) < 5));
         check($sformatf("ph3_b_k%0d", k), 32'(out_b), 32'(((k + 7) % 10) < 5));
         tick();
      end
      tick();
      // Reconfigure while running at cnt_a=1
      send_cfg(32'd12, 32'd6, 32'd0);
      for (int k = 202; k < 210; k++) begin
         check($sformatf("rcfg_ready_k%0d", k), 32'(cfg_ready), 0);
         check($sformatf("rcfg_old_a_k%0d", k), 32'(out_a), 32'((k % 10) < 5));
         check($sformatf("rcfg_old_b_k%0d", k), 32'(out_b), 32'(((k + 7) % 10) < 5));
         tick();
      end
      check("rcfg_ready_boundary", 32'(cfg_ready), 1);
      for (int j = 0; j < 24; j++) begin
         check($sformatf("rcfg_new_a_j%0d", j), 32'(out_a), 32'((j % 12) < 6));
         check($sformatf("rcfg_new_b_j%0d", j), 32'(out_b), 32'((j % 12) < 6));
         tick();
      end

      // Asynchronous reset mid-pulse (out_a high at cnt_a=0)
      check("pre_rst_out_a", 32'(out_a), 1);
      rst_n = 1'b0;
      #1;
      check("async_rst_out_a", 32'(out_a), 0);
      check("async_rst_out_b", 32'(out_b), 0);
      check("async_rst_busy", 32'(busy), 0);
      check("async_rst_ready", 32'(cfg_ready), 1);
      tick();
      rst_n = 1'b1;
      tick();
      repeat (3) tick();
      check("noload_busy", 32'(busy), 0);
      check("noload_out_a", 32'(out_a), 0);
      enable = 1'b0;
      tick();

      // Minimal valid config; enable falls on the boundary edge
      send_cfg(32'd2, 32'd1, 32'd1);
      check("min_err", 32'(cfg_err), 0);
      check("min_ready", 32'(cfg_ready), 0);
      tick();
      enable = 1'b1;
      tick();
      for (int k = 0; k < 5; k++) begin
         check($sformatf("min_a_k%0d", k), 32'(out_a), 32'((k % 2) == 0));
         check($sformatf("min_b_k%0d", k), 32'(out_b), 32'((k % 2) == 1));
         tick();
      end
      enable = 1'b0;
      tick();
      check("bnd_stop_busy", 32'(busy), 0);
      check("bnd_stop_out_a", 32'(out_a), 0);
      check("bnd_stop_out_b", 32'(out_b), 0);
`ifdef TSG_PCNT_EN
      check("bnd_stop_pcnt", pcnt, 3);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
